zapper_shot_ctrl: RTL and testbench
===================================

Name: zapper_shot_ctrl

Overview:
- Sequences the light-gun shot for the duck game: on a trigger pull it requests one all-black frame, then one target frame showing only the white target box.
- Integrates the photodiode detect input over the target frame and declares a hit or a miss.
- Tracks shots remaining and score.
- Sits between the zapper pins and the pattern generator; the pattern generator selects its colour source from flash_mode.

Parameters:
- SHOTS_PER_ROUND, 3, shots granted per round (1..7).
- SCORE_W, 16, score counter width.
- HIT_POINTS, 500, added to score per hit.
- DETECT_MIN, 64, minimum clk cycles of detect high in the target frame that count as a hit (1..2^16-1).
- SYNC_STAGES, 2, flip-flop synchroniser depth on trigger and detect (>=2).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse at the first cycle of vertical blank.
- trigger  in  1  raw zapper trigger, active-high, asynchronous.
- detect  in  1  raw zapper photodiode, active-high, asynchronous.
- new_round  in  1  one-cycle pulse; reloads shots and clears the hit/miss state.
- flash_mode  out  2  0 = NORMAL, 1 = BLACK, 2 = TARGET (3 is never driven).
- shot_busy  out  1  high from trigger acceptance until EVAL completes.
- hit  out  1  one-cycle pulse on a hit.
- miss  out  1  one-cycle pulse on a miss.
- shots_left  out  3  remaining shots.
- score  out  SCORE_W  accumulated score.

Behaviour:
- Reset (rst low at a clk edge):
  - flash_mode = 0, shot_busy = 0, hit = 0, miss = 0.
  - shots_left = SHOTS_PER_ROUND, score = 0.
  - State = IDLE; synchronisers cleared; detect counter = 0.
  - Reset wins over every other input in the same cycle.
- Synchronisers: trigger and detect each pass through SYNC_STAGES flops. trig_rise = synchronised trigger high and its previous value low.
- IDLE:
  - If trig_rise and shots_left != 0: decrement shots_left and go to ARM; shot_busy rises on the next cycle.
  - If trig_rise and shots_left == 0: ignore it and stay in IDLE.
- ARM: wait for frame_start, then go to BLACK. flash_mode stays 0.
- BLACK: flash_mode = 1 for one full frame. At the next frame_start go to TARGET and clear the detect counter.
- TARGET:
  - flash_mode = 2.
  - The 16-bit detect counter increments on each cycle the synchronised detect is high, saturating at 0xFFFF.
  - At the next frame_start go to EVAL.
- EVAL (exactly one cycle, flash_mode = 0):
  - If counter >= DETECT_MIN: hit = 1 and score += HIT_POINTS. Score saturates at all-ones and never wraps.
  - Otherwise miss = 1.
  - Next state is RELEASE; shot_busy drops.
- RELEASE: wait until the synchronised trigger is low, then go to IDLE. A held trigger never fires a second shot.
- flash_mode changes only on the cycle after frame_start, so the pattern generator sees a constant mode for a whole frame.
- A frame_start arriving in the same cycle as trig_rise in IDLE does not advance ARM. BLACK starts at the following frame_start.
- new_round:
  - Reloads shots_left to SHOTS_PER_ROUND and forces the state to IDLE with flash_mode = 0.
  - An in-flight shot is abandoned with no hit or miss pulse. Score is preserved.
  - new_round in the same cycle as trig_rise: new_round wins and the trigger edge is dropped.
- hit and miss are mutually exclusive and never both high in one cycle.

Optional Feature:
- Macro: ZAPPER_BLACK_CHECK_EN.
- When defined:
  - A second counter counts synchronised detect-high cycles during BLACK.
  - If that count >= DETECT_MIN, the shot is forced to a miss in EVAL regardless of the TARGET count. This defeats aiming the zapper at a lamp.
- When undefined: detect is ignored during BLACK, and no BLACK-phase counter is synthesised.

Test Plan:
- Reset, then pulse trigger and hold detect high for 200 cycles inside the TARGET frame (DETECT_MIN = 64) → flash_mode reads 0, 1, 2, 0 on consecutive frames; one hit pulse; score = 500; shots_left = 2.
- Same shot with detect high for only 10 cycles → miss pulse, score unchanged, shots_left = 2.
- Three accepted shots, then a fourth trig_rise → the fourth is ignored, shots_left stays 0, flash_mode stays 0. new_round → shots_left = 3.
- Hold trigger high across EVAL and three more frames → exactly one shot; the next shot is accepted only after release and re-press.
- Assert new_round during TARGET → flash_mode = 0 next cycle, no hit or miss pulse, shots_left = 3, score unchanged.
- With ZAPPER_BLACK_CHECK_EN defined: detect high 100 cycles in BLACK and 100 cycles in TARGET → miss. Without the macro, the same stimulus → hit.

Source files
------------

// File: rtl/zapper_shot_ctrl.sv
// Light-gun shot sequencer: black frame, target frame, photodiode integration, hit/miss scoring.
// Optional macro ZAPPER_BLACK_CHECK_EN adds a detect counter over the black frame that vetoes hits.
module zapper_shot_ctrl #(
  parameter int unsigned SHOTS_PER_ROUND = 3,
  parameter int unsigned SCORE_W         = 16,
  parameter int unsigned HIT_POINTS      = 500,
  parameter int unsigned DETECT_MIN      = 64,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               trigger,
  input  logic               detect,
  input  logic               new_round,
  output logic [1:0]         flash_mode,
  output logic               shot_busy,
  output logic               hit,
  output logic               miss,
  output logic [2:0]         shots_left,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SHOT_W = 3;
  localparam int unsigned SUM_W  = SCORE_W + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  DET_MIN    = CNT_W'(DETECT_MIN);
  localparam logic [SHOT_W-1:0] SHOTS_INIT = SHOT_W'(SHOTS_PER_ROUND);
  localparam logic [SUM_W-1:0]  PTS        = SUM_W'(HIT_POINTS);

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_BLACK  = 2'd1;
  localparam logic [1:0] MODE_TARGET = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TARGET,
    S_EVAL,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_trig_sync;
  logic [SYNC_STAGES-1:0] r_det_sync;
  logic                   r_trig_prev;
  logic                   w_trig_s;
  logic                   w_det_s;
  logic                   w_trig_rise;

  logic [CNT_W-1:0]   r_tgt_cnt;
  logic [1:0]         r_flash;
  logic               r_busy;
  logic               r_hit;
  logic               r_miss;
  logic [SHOT_W-1:0]  r_shots;
  logic [SCORE_W-1:0] r_score;

  logic               w_accept;
  logic               w_eval;
  logic               w_tgt_clr;
  logic               w_pass;
  logic [1:0]         w_flash_nxt;
  logic               w_busy_nxt;
  logic               w_hit_nxt;
  logic               w_miss_nxt;
  logic [SUM_W-1:0]   w_score_sum;

`ifdef ZAPPER_BLACK_CHECK_EN
  logic [CNT_W-1:0] r_blk_cnt;
  logic             w_blk_clr;
`endif

  assign w_trig_s    = r_trig_sync[SYNC_STAGES-1];
  assign w_det_s     = r_det_sync[SYNC_STAGES-1];
  assign w_trig_rise = w_trig_s & ~r_trig_prev;

  // Metastability synchronisers and trigger edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_trig_sync <= '0;
      r_det_sync  <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_sync <= {r_trig_sync[SYNC_STAGES-2:0], trigger};
      r_det_sync  <= {r_det_sync[SYNC_STAGES-2:0], detect};
      r_trig_prev <= w_trig_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus registered-output next values; new_round overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_eval      = 1'b0;
    w_tgt_clr   = 1'b0;
    w_flash_nxt = MODE_NORMAL;
    w_busy_nxt  = 1'b0;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
`ifdef ZAPPER_BLACK_CHECK_EN
    w_blk_clr   = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_trig_rise && (r_shots != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (frame_start) begin
          w_state_nxt = S_BLACK;
`ifdef ZAPPER_BLACK_CHECK_EN
          w_blk_clr   = 1'b1;
`endif
        end
      end
      S_BLACK: begin
        if (frame_start) begin
          w_state_nxt = S_TARGET;
          w_tgt_clr   = 1'b1;
        end
      end
      S_TARGET: begin
        if (frame_start) begin
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_trig_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (new_round) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_eval      = 1'b0;
    end

    case (w_state_nxt)
      S_BLACK:  w_flash_nxt = MODE_BLACK;
      S_TARGET: w_flash_nxt = MODE_TARGET;
      default:  w_flash_nxt = MODE_NORMAL;
    endcase

    w_busy_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_BLACK) ||
                 (w_state_nxt == S_TARGET) || (w_state_nxt == S_EVAL);
    w_hit_nxt  = w_eval & w_pass;
    w_miss_nxt = w_eval & ~w_pass;
  end

`ifdef ZAPPER_BLACK_CHECK_EN
  assign w_pass = (r_tgt_cnt >= DET_MIN) && (r_blk_cnt < DET_MIN);

  // Light seen while the screen is black means the gun is aimed at a lamp
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blk_cnt <= '0;
    end else if (w_blk_clr) begin
      r_blk_cnt <= '0;
    end else if ((r_state == S_BLACK) && w_det_s && (r_blk_cnt != CNT_MAX)) begin
      r_blk_cnt <= r_blk_cnt + CNT_W'(1);
    end
  end
`else
  assign w_pass = (r_tgt_cnt >= DET_MIN);
`endif

  // Saturating detect integrator over the target frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tgt_cnt <= '0;
    end else if (w_tgt_clr) begin
      r_tgt_cnt <= '0;
    end else if ((r_state == S_TARGET) && w_det_s && (r_tgt_cnt != CNT_MAX)) begin
      r_tgt_cnt <= r_tgt_cnt + CNT_W'(1);
    end
  end

  assign w_score_sum = {1'b0, r_score} + PTS;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flash <= MODE_NORMAL;
      r_busy  <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_shots <= SHOTS_INIT;
      r_score <= '0;
    end else begin
      r_flash <= w_flash_nxt;
      r_busy  <= w_busy_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
      if (new_round) begin
        r_shots <= SHOTS_INIT;
      end else if (w_accept) begin
        r_shots <= r_shots - SHOT_W'(1);
      end
      if (w_hit_nxt) begin
        r_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
      end
    end
  end

  assign flash_mode = r_flash;
  assign shot_busy  = r_busy;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign shots_left = r_shots;
  assign score      = r_score;

endmodule

// File: tb/tb_zapper_shot_ctrl.sv
// Self-checking bench for zapper_shot_ctrl: frame-level stimulus against a shot/score model.
module tb_zapper_shot_ctrl;

  localparam int FRAME = 320;
  localparam int DMIN  = 64;
  localparam int PTS   = 500;
  localparam int NSHOT = 3;
`ifdef ZAPPER_BLACK_CHECK_EN
  localparam bit BLK_CHK = 1'b1;
`else
  localparam bit BLK_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        trigger;
  logic        detect;
  logic        new_round;
  logic [1:0]  flash_mode;
  logic        shot_busy;
  logic        hit;
  logic        miss;
  logic [2:0]  shots_left;
  logic [15:0] score;

  int tests = 0;
  int fails = 0;
  int exp_score = 0;
  int exp_shots = NSHOT;

  logic [1:0] f_mid_flash;
  logic       f_mid_busy;
  logic [2:0] f_mid_shots;
  logic [1:0] f_nr_flash;
  int         f_hits;
  int         f_miss;
  int         flash_glitch = 0;
  int         both_seen = 0;

  always #5 clk = ~clk;

  zapper_shot_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .trigger     (trigger),
    .detect      (detect),
    .new_round   (new_round),
    .flash_mode  (flash_mode),
    .shot_busy   (shot_busy),
    .hit         (hit),
    .miss        (miss),
    .shots_left  (shots_left),
    .score       (score)
  );

  function automatic bit model_hit(input int blk, input int tgt);
    return (tgt >= DMIN) && !(BLK_CHK && (blk >= DMIN));
  endfunction

  function automatic int model_score(input int s);
    return (s + PTS > 65535) ? 65535 : s + PTS;
  endfunction

  // One video frame: frame_start at cycle 0, detect window and trigger/new_round events at given cycles
  task automatic run_frame(input int det_start, input int det_len, input int trig_on,
                           input int trig_off, input int nr_at);
    logic [1:0] first_flash;
    bit         changed;
    first_flash = 2'd0;
    changed     = 1'b0;
    f_hits      = 0;
    f_miss      = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (hit) f_hits++;
      if (miss) f_miss++;
      if (hit && miss) both_seen++;
      if (c == 1) first_flash = flash_mode;
      else if (c > 1 && flash_mode !== first_flash) changed = 1'b1;
      if (c == FRAME / 2) begin
        f_mid_flash = flash_mode;
        f_mid_busy  = shot_busy;
        f_mid_shots = shots_left;
      end
      if (nr_at >= 0 && c == nr_at + 1) f_nr_flash = flash_mode;
      frame_start = (c == 0);
      detect      = (c >= det_start) && (c < det_start + det_len);
      if (c == trig_on)  trigger = 1'b1;
      if (c == trig_off) trigger = 1'b0;
      new_round = (c == nr_at);
    end
    if (changed && nr_at < 0) flash_glitch++;
  endtask

  task automatic do_shot(input int blk_len, input int tgt_len, output logic [7:0] modes,
                         output logic [3:0] busy, output int hits, output int misses,
                         output logic [2:0] shots_mid);
    hits   = 0;
    misses = 0;
    modes  = '0;
    busy   = '0;
    shots_mid = '0;
    for (int f = 0; f < 4; f++) begin
      case (f)
        0:       run_frame(0, 0, 20, 40, -1);
        1:       run_frame(100, blk_len, -1, -1, -1);
        2:       run_frame(100, tgt_len, -1, -1, -1);
        default: run_frame(0, 0, -1, -1, -1);
      endcase
      modes[2*f +: 2] = f_mid_flash;
      busy[f] = f_mid_busy;
      hits   += f_hits;
      misses += f_miss;
      if (f == 0) shots_mid = f_mid_shots;
    end
  endtask

  task automatic pulse_new_round();
    @(negedge clk);
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    exp_shots = NSHOT;
  endtask

  task automatic test_reset();
    rst = 1'b0; frame_start = 1'b0; trigger = 1'b0; detect = 1'b0; new_round = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (flash_mode !== 2'd0) begin fails++; $display("FAIL reset_flash got=%0d exp=0", flash_mode); end
    tests++; if (shot_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", shot_busy); end
    tests++; if (hit !== 1'b0 || miss !== 1'b0) begin fails++; $display("FAIL reset_hitmiss got=%b%b exp=00", hit, miss); end
    tests++; if (shots_left !== 3'(NSHOT)) begin fails++; $display("FAIL reset_shots got=%0d exp=%0d", shots_left, NSHOT); end
    tests++; if (score !== 16'd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", score); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_shot(input string nm, input int blk, input int tgt);
    logic [7:0] m; logic [3:0] b; int h; int mi; logic [2:0] s; bit eh;
    eh = model_hit(blk, tgt);
    do_shot(blk, tgt, m, b, h, mi, s);
    exp_shots--;
    if (eh) exp_score = model_score(exp_score);
    tests++; if (m !== 8'b00_10_01_00) begin fails++; $display("FAIL %s_modes got=%b exp=00100100", nm, m); end
    tests++; if (b !== 4'b0111) begin fails++; $display("FAIL %s_busy got=%b exp=0111", nm, b); end
    tests++; if (h !== int'(eh) || mi !== int'(!eh)) begin fails++; $display("FAIL %s_result got hit=%0d miss=%0d exp hit=%0d", nm, h, mi, eh); end
    tests++; if (s !== 3'(exp_shots)) begin fails++; $display("FAIL %s_shots_mid got=%0d exp=%0d", nm, s, exp_shots); end
    tests++; if (score !== 16'(exp_score)) begin fails++; $display("FAIL %s_score got=%0d exp=%0d", nm, score, exp_score); end
  endtask

  task automatic test_hit_basic();
    check_shot("hit_basic", 0, 200);
    tests++; if (shots_left !== 3'd2) begin fails++; $display("FAIL hit_basic_shots got=%0d exp=2", shots_left); end
  endtask

  task automatic test_miss_basic();
    pulse_new_round();
    check_shot("miss_basic", 0, 10);
    tests++; if (shots_left !== 3'd2) begin fails++; $display("FAIL miss_basic_shots got=%0d exp=2", shots_left); end
  endtask

  task automatic test_threshold();
    pulse_new_round();
    check_shot("thr_eq", 0, DMIN);
    check_shot("thr_below", 0, DMIN - 1);
  endtask

  task automatic test_exhaust();
    logic [2:0] mids; logic [2:0] busys; int hm;
    pulse_new_round();
    for (int i = 0; i < NSHOT; i++) check_shot("exhaust", 0, int'($urandom_range(200)));
    tests++; if (shots_left !== 3'd0) begin fails++; $display("FAIL exhaust_empty got=%0d exp=0", shots_left); end
    hm = 0; mids = '0; busys = '0;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) run_frame(0, 0, 20, 40, -1);
      else        run_frame(100, 150, -1, -1, -1);
      mids[f] = (f_mid_flash != 2'd0);
      busys[f] = f_mid_busy;
      hm += f_hits + f_miss;
    end
    tests++; if (mids !== 3'b000 || busys !== 3'b000 || hm != 0) begin fails++; $display("FAIL exhaust_ignored got flash=%b busy=%b pulses=%0d exp 000/000/0", mids, busys, hm); end
    tests++; if (shots_left !== 3'd0) begin fails++; $display("FAIL exhaust_still_empty got=%0d exp=0", shots_left); end
    pulse_new_round();
    tests++; if (shots_left !== 3'(NSHOT)) begin fails++; $display("FAIL exhaust_reload got=%0d exp=%0d", shots_left, NSHOT); end
  endtask

  task automatic test_held_trigger();
    int h; logic [2:0] mids; logic [2:0] busys;
    pulse_new_round();
    h = 0; mids = '0; busys = '0;
    run_frame(0, 0, 20, -1, -1);   h += f_hits;
    run_frame(0, 0, -1, -1, -1);   h += f_hits;
    run_frame(100, 200, -1, -1, -1); h += f_hits;
    run_frame(0, 0, -1, -1, -1);   h += f_hits;
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0, -1, -1, -1);
      h += f_hits;
      mids[f] = (f_mid_flash != 2'd0);
      busys[f] = f_mid_busy;
    end
    exp_shots--;
    exp_score = model_score(exp_score);
    tests++; if (h != 1) begin fails++; $display("FAIL held_hits got=%0d exp=1", h); end
    tests++; if (mids !== 3'b000 || busys !== 3'b000) begin fails++; $display("FAIL held_refire got flash=%b busy=%b exp 000/000", mids, busys); end
    tests++; if (shots_left !== 3'(exp_shots)) begin fails++; $display("FAIL held_shots got=%0d exp=%0d", shots_left, exp_shots); end
    run_frame(0, 0, -1, 10, -1);
    check_shot("held_repress", 0, 150);
  endtask

  task automatic test_new_round_target();
    int hm; int sc;
    pulse_new_round();
    check_shot("pre_abort", 0, 0);
    sc = exp_score;
    hm = 0;
    run_frame(0, 0, 20, 40, -1);
    run_frame(0, 0, -1, -1, -1);
    run_frame(100, 100, -1, -1, 150); hm += f_hits + f_miss;
    exp_shots = NSHOT;
    tests++; if (f_nr_flash !== 2'd0) begin fails++; $display("FAIL abort_flash got=%0d exp=0", f_nr_flash); end
    run_frame(0, 0, -1, -1, -1); hm += f_hits + f_miss;
    tests++; if (hm != 0) begin fails++; $display("FAIL abort_pulses got=%0d exp=0", hm); end
    tests++; if (f_mid_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", f_mid_busy); end
    tests++; if (shots_left !== 3'(NSHOT)) begin fails++; $display("FAIL abort_shots got=%0d exp=%0d", shots_left, NSHOT); end
    tests++; if (score !== 16'(sc)) begin fails++; $display("FAIL abort_score got=%0d exp=%0d", score, sc); end
  endtask

  task automatic test_black_check();
    pulse_new_round();
    check_shot("black_chk", 100, 100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if (exp_shots == 0) pulse_new_round();
      check_shot("random", int'($urandom_range(150)), int'($urandom_range(200)));
    end
  endtask

  task automatic test_invariants();
    tests++; if (flash_glitch != 0) begin fails++; $display("FAIL flash_stable got=%0d glitching frames exp=0", flash_glitch); end
    tests++; if (both_seen != 0) begin fails++; $display("FAIL hit_miss_exclusive got=%0d overlaps exp=0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_miss_basic();
    test_threshold();
    test_exhaust();
    test_held_trigger();
    test_new_round_target();
    test_black_check();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
